// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register-select width and hazard-controller states.
package cpu_types_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RST    = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } hz_state_t;

endpackage

// File: rtl/hz_stall_counter.sv
// Saturating cycle counter with enable; holds at all-ones, cleared only by reset.
module hz_stall_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;

  // Count enabled cycles, sticking at the maximum value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= {CNT_W{1'b0}};
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_q <= count_q + CNT_ONE;
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller driving write-enable and flush for NSTAGES pipeline
// registers, with halt drain and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned NSTAGES   = 4,
  parameter int unsigned MEM_STAGE = NSTAGES - 2,
  parameter int unsigned BR_STAGE  = 1,
  parameter int unsigned REGW      = REG_W,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               mem_ren,
  input  logic               mem_wen,
  input  logic               ex_memread,
  input  logic [REGW-1:0]    ex_wsel,
  input  logic [REGW-1:0]    id_rs,
  input  logic [REGW-1:0]    id_rt,
  input  logic               id_uses_rt,
  input  logic               redirect,
  input  logic               id_halt,
  input  logic               wb_halt,
  output logic [NSTAGES-1:0] stage_w,
  output logic [NSTAGES-1:0] stage_flush,
  output logic               pcWEN,
  output logic               halted,
  output logic [CNT_W-1:0]   stall_count
);

  localparam logic [NSTAGES-1:0] ALL_ONES  = {NSTAGES{1'b1}};
  localparam logic [NSTAGES-1:0] ALL_ZEROS = {NSTAGES{1'b0}};
  localparam logic [NSTAGES-1:0] BIT0      = {{(NSTAGES-1){1'b0}}, 1'b1};
  localparam logic [NSTAGES-1:0] BIT1      = BIT0 << 1;
  // Registers IF/ID up to and including the branch-resolve register.
  localparam logic [NSTAGES-1:0] BR_MASK   = ALL_ONES >> (NSTAGES - 1 - BR_STAGE);

  hz_state_t state_q;
  logic      halted_q;

  logic mem_req_s, freeze_s, lu_match_s, load_use_s, running_s, cnt_en_s;
  logic [NSTAGES-1:0] base_w_s, base_flush_s, stage_w_s, stage_flush_s;
  logic base_pc_s, pc_wen_s;

  // A data request only counts when MEM_STAGE names a real pipeline register.
  assign mem_req_s  = (mem_ren | mem_wen) & (MEM_STAGE < NSTAGES);
  assign freeze_s   = mem_req_s & ~dhit;
  assign lu_match_s = (ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt));
  assign load_use_s = ex_memread & (ex_wsel != {REGW{1'b0}}) & lu_match_s;
  assign running_s  = (state_q == RUN) | (state_q == DRAIN);

  // Hazard priority while running, before any drain override.
  always_comb begin
    base_w_s     = ALL_ONES;
    base_flush_s = ALL_ZEROS;
    base_pc_s    = 1'b0;
    if (freeze_s) begin
      base_w_s     = ALL_ZEROS;
      base_flush_s = ALL_ZEROS;
      base_pc_s    = 1'b0;
    end else if (load_use_s) begin
      base_w_s     = ALL_ONES & ~BIT0;
      base_flush_s = BIT1;
      base_pc_s    = 1'b0;
    end else if (redirect) begin
      base_w_s     = ALL_ONES;
      base_flush_s = BR_MASK;
      base_pc_s    = 1'b1;
    end else if (!ihit) begin
      base_w_s     = ALL_ONES;
      base_flush_s = BIT0;
      base_pc_s    = 1'b0;
    end else begin
      base_w_s     = ALL_ONES;
      base_flush_s = ALL_ZEROS;
      base_pc_s    = ihit;
    end
  end

  // Per-state output selection; DRAIN blocks fetch by bubbling IF/ID.
  always_comb begin
    stage_w_s     = ALL_ZEROS;
    stage_flush_s = ALL_ONES;
    pc_wen_s      = 1'b0;
    case (state_q)
      RST: begin
        stage_w_s     = ALL_ZEROS;
        stage_flush_s = ALL_ONES;
        pc_wen_s      = 1'b0;
      end
      RUN: begin
        stage_w_s     = base_w_s;
        stage_flush_s = base_flush_s;
        pc_wen_s      = base_pc_s;
      end
      DRAIN: begin
        stage_w_s     = base_w_s;
        stage_flush_s = base_flush_s | BIT0;
        pc_wen_s      = 1'b0;
      end
      HALTED: begin
        stage_w_s     = ALL_ZEROS;
        stage_flush_s = ALL_ZEROS;
        pc_wen_s      = 1'b0;
      end
      default: begin
        stage_w_s     = ALL_ZEROS;
        stage_flush_s = ALL_ONES;
        pc_wen_s      = 1'b0;
      end
    endcase
  end

  // Controller FSM with registered halt flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= RST;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        RST: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
        RUN: begin
          if (wb_halt) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else if (id_halt && !freeze_s) begin
            state_q  <= DRAIN;
            halted_q <= 1'b0;
          end else begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (wb_halt) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else begin
            state_q  <= DRAIN;
            halted_q <= 1'b0;
          end
        end
        HALTED: begin
          state_q  <= HALTED;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= RST;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Drain-forced PC holds are not hazards, so count on the pre-override enable.
  assign cnt_en_s = running_s & ~base_pc_s;

  hz_stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .en_i    (cnt_en_s),
    .count_o (stall_count)
  );

  assign stage_w     = stage_w_s;
  assign stage_flush = stage_flush_s;
  assign pcWEN       = pc_wen_s;
  assign halted      = halted_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised stall/flush controller for the in-order pipelined datapath. It replaces the fixed four-register hazard logic with one block that drives write-enable and flush for any number of pipeline registers. It handles instruction-fetch wait, data-memory wait, load-use interlock, taken-branch/jump flush at a configurable resolve stage, and halt drain, and it counts stall cycles. It sits beside the datapath, between the pipeline registers and the cache interface hit signals.

## Interface
- NSTAGES, 4, number of pipeline registers; index 0 = IF/ID … NSTAGES-1 = MEM/WB
- MEM_STAGE, NSTAGES-2, index of the register whose outputs drive dmemREN/dmemWEN
- BR_STAGE, 1, index of the register whose outputs feed branch/jump resolution
- REGW, 5, register-select width
- CNT_W, 16, stall counter width
- CLK  in  1  clock, rising edge
- nRST  in  1  reset; asynchronous and active-low
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- mem_ren, mem_wen  in  1 each  data request from register MEM_STAGE
- ex_memread  in  1  instruction in EX is a load
- ex_wsel  in  REGW  destination of the instruction in EX
- id_rs, id_rt  in  REGW  sources of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- redirect  in  1  taken branch, jump, or JR resolved from register BR_STAGE
- id_halt  in  1  HALT decoded in ID
- wb_halt  in  1  HALT present at output of register NSTAGES-1
- stage_w  out  NSTAGES  per-register write enable
- stage_flush  out  NSTAGES  per-register synchronous clear-to-bubble (takes priority over stage_w in the register)
- pcWEN  out  1  PC update enable
- halted  out  1  sticky halt indication
- stall_count  out  CNT_W  saturating stall-cycle counter

## Operation
- FSM states: RST, RUN, DRAIN, HALTED. Asynchronous reset enters RST.
- RST → RUN on the first clock edge after reset is released.
- RUN → DRAIN when id_halt is high and no freeze applies.
- RUN or DRAIN → HALTED when wb_halt is high. HALTED is left only by reset.
- In RST and HALTED:
  - stage_w = 0, pcWEN = 0.
  - stage_flush = all ones in RST, all zeros in HALTED.
- Priority in RUN/DRAIN, highest first:
  1. Data freeze: (mem_ren|mem_wen) & !dhit. stage_w = 0, stage_flush = 0, pcWEN = 0.
  2. Load-use: ex_memread & ex_wsel≠0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)). stage_w[0] = 0, stage_flush[1] = 1, all other stage_w = 1, pcWEN = 0.
  3. Redirect: all stage_w = 1, stage_flush[0..BR_STAGE] = 1, pcWEN = 1 (PC loads the target).
  4. Fetch wait: !ihit. stage_w = all ones, stage_flush[0] = 1, pcWEN = 0.
  5. Normal: stage_w = all ones, stage_flush = 0, pcWEN = ihit.
- DRAIN adds two overrides on top of the rules above:
  - pcWEN is forced to 0.
  - stage_flush[0] is forced to 1, so no new instruction enters the pipeline.
- halted = 1 exactly in state HALTED.
- stall_count:
  - Increments once per cycle in RUN/DRAIN while pcWEN = 0, excluding DRAIN-forced cycles.
  - Saturates at 2^CNT_W−1. Cleared only by reset.

## Timing
- stage_w, stage_flush, and pcWEN are combinational (Mealy) from the inputs and the registered state, valid in the same cycle.
- State and stall_count update on the rising edge of CLK.
- Reset values: state RST, halted = 0, stall_count = 0, stage_w = 0, stage_flush = all ones, pcWEN = 0.
- Simultaneous events:
  - wb_halt together with a data freeze: freeze applies this cycle; HALTED is entered at the edge.
  - Redirect together with load-use: load-use wins; the redirect is re-presented the next cycle because register BR_STAGE did not advance past it.
- Reset asserted mid-freeze forces the RST outputs immediately (asynchronous); nothing is latched across reset.

## Structure
- Shared package cpu_types_pkg gains:
  - the hz_state_t enum {RST, RUN, DRAIN, HALTED};
  - a regbits_t typedef used for REGW.
- Optional sub-module: hz_stall_counter (saturating CNT_W counter with enable).
- Everything else lives in pipeline_hazard_ctrl.

## Test plan
- Reset with nRST low for 3 cycles, then release → outputs show reset values; RUN after the first edge; with ihit=1, pcWEN=1 and stage_w=4'b1111.
- mem_ren=1, dhit=0 for 5 cycles, then dhit=1 → stage_w=0 and pcWEN=0 for 5 cycles, all ones on the dhit cycle; stall_count=5.
- ex_memread=1, ex_wsel=8, id_rs=8 → stage_w=4'b1110, stage_flush=4'b0010, pcWEN=0. Repeat with ex_wsel=0 → no stall.
- redirect=1 with BR_STAGE=1 → stage_flush=4'b0011, pcWEN=1. Rebuild with NSTAGES=6, BR_STAGE=2 → stage_flush=6'b000111.
- id_halt pulse, then wb_halt three cycles later → pcWEN=0 and stage_flush[0]=1 during DRAIN; halted=1 after wb_halt; stays 1 with ihit toggling until reset.
- CNT_W=3 with ihit=0 for 10 cycles → stall_count saturates at 7.
